// File: rtl/scan_sel_2_4_seq.sv
// Round-robin scan sequencer driving a 2x4 decoder: per-slot dwell, optional
// blanking gap, slot skip mask, run/stop control and a frame-start pulse.
module scan_sel_2_4_seq #(
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned BLANK_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [BLANK_W-1:0] blank,
  input  logic [3:0]         mask,
  output logic [1:0]         Sel,
  output logic               En,
  output logic               frame,
  output logic               busy
);

  localparam int unsigned CNT_W = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON    = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [1:0]       sel_d;
  logic             en_d;
  logic             frame_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [DWELL_W-1:0] dwell_m1;
  logic [1:0]       adv_sel;

  // First set slot after k, wrapping, with k itself checked last.
  function automatic logic [1:0] next_slot(input logic [1:0] k, input logic [3:0] m);
    logic [1:0] r;
    logic [1:0] j;
    r = k;
    for (int i = 4; i >= 1; i--) begin
      j = k + 2'(i);
      if (m[j]) r = j;
    end
    return r;
  endfunction

  assign dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign adv_sel  = next_slot(Sel, mask);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      Sel   <= 2'd0;
      En    <= 1'b0;
      frame <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      Sel   <= sel_d;
      En    <= en_d;
      frame <= frame_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state and registered-output logic; run=0 takes priority over advancing.
  always_comb begin
    state_d = state;
    sel_d   = Sel;
    en_d    = En;
    frame_d = 1'b0;
    cnt_d   = cnt;

    unique case (state)
      IDLE: begin
        en_d = 1'b0;
        if (run && (mask != 4'd0)) begin
          sel_d   = next_slot(2'd3, mask);
          en_d    = 1'b1;
          cnt_d   = CNT_W'(dwell_m1);
          frame_d = 1'b1;
          state_d = ON;
        end
      end
      ON, BLANK: begin
        if (!run) begin
          en_d    = 1'b0;
          state_d = IDLE;
        end else if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else if ((state == ON) && (blank != '0)) begin
          en_d    = 1'b0;
          cnt_d   = CNT_W'(blank) - CNT_W'(1);
          state_d = BLANK;
        end else if (mask == 4'd0) begin
          en_d    = 1'b0;
          state_d = IDLE;
        end else begin
          sel_d   = adv_sel;
          en_d    = 1'b1;
          cnt_d   = CNT_W'(dwell_m1);
          frame_d = (adv_sel <= Sel);
          state_d = ON;
        end
      end
      default: begin
        en_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_scan_sel_2_4_seq.sv
// Bench for scan_sel_2_4_seq: elapsed-time reference model checked every cycle,
// plus directed sequences with literal expected patterns.
module tb_scan_sel_2_4_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [15:0] dwell;
  logic [7:0]  blank;
  logic [3:0]  mask;
  logic [1:0]  Sel;
  logic        En;
  logic        frame;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: slot index plus cycles elapsed inside the slot.
  bit        m_active;
  bit        m_en;
  bit        m_frame;
  bit [1:0]  m_sel;
  int        m_age;
  int        m_d;
  int        m_b;

  scan_sel_2_4_seq #(.DWELL_W(16), .BLANK_W(8)) dut (
    .clk(clk), .rst(rst), .run(run), .dwell(dwell), .blank(blank), .mask(mask),
    .Sel(Sel), .En(En), .frame(frame), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic bit [1:0] m_next(input bit [1:0] k, input bit [3:0] m);
    for (int i = 1; i <= 4; i++) begin
      int j;
      j = (int'(k) + i) % 4;
      if (m[j]) return 2'(j);
    end
    return k;
  endfunction

  function automatic int eff_dwell(input logic [15:0] d);
    return (d == 16'd0) ? 1 : int'(d);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_advance();
    bit [1:0] nsel;
    if (mask == 4'd0) begin
      m_active = 0;
      m_en     = 0;
    end else begin
      nsel    = m_next(m_sel, mask);
      m_frame = (nsel <= m_sel);
      m_sel   = nsel;
      m_en    = 1;
      m_d     = eff_dwell(dwell);
      m_age   = 0;
    end
  endtask

  task automatic model_update();
    m_frame = 0;
    if (rst) begin
      m_active = 0; m_en = 0; m_sel = 2'd0; m_age = 0;
    end else if (!m_active) begin
      if (run && mask != 4'd0) begin
        m_active = 1;
        m_sel    = m_next(2'd3, mask);
        m_en     = 1;
        m_frame  = 1;
        m_d      = eff_dwell(dwell);
        m_age    = 0;
      end
    end else if (!run) begin
      m_active = 0;
      m_en     = 0;
    end else if (m_en) begin
      if (m_age < m_d - 1) m_age++;
      else if (blank == 8'd0) m_advance();
      else begin
        m_b = int'(blank);
        m_en = 0;
        m_age++;
      end
    end else begin
      if (m_age < m_d - 1 + m_b) m_age++;
      else m_advance();
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("model_sel",   int'(Sel),   int'(m_sel));
    check("model_en",    int'(En),    int'(m_en));
    check("model_frame", int'(frame), int'(m_frame));
    check("model_busy",  int'(busy),  int'(m_active));
  endtask

  task automatic do_reset();
    rst = 1; run = 0;
    step(); step();
    rst = 0;
  endtask

  initial begin
    rst = 1; run = 1; mask = 4'hF; dwell = 16'd3; blank = 8'd0;
    m_active = 0; m_en = 0; m_frame = 0; m_sel = 0; m_age = 0; m_d = 1; m_b = 0;

    // Reset held with run asserted: outputs stay at reset values.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_sel", int'(Sel), 0);
      check("rst_en", int'(En), 0);
      check("rst_frame", int'(frame), 0);
      check("rst_busy", int'(busy), 0);
    end

    // dwell=3, blank=0, all slots.
    rst = 0; run = 0;
    step();
    check("idle_busy", int'(busy), 0);
    run = 1;
    for (int i = 0; i < 13; i++) begin
      step();
      check("d3_sel", int'(Sel), (i / 3) % 4);
      check("d3_en", int'(En), 1);
      check("d3_frame", int'(frame), (i == 0 || i == 12) ? 1 : 0);
    end

    // dwell=2, blank=2: ON,ON,gap,gap per slot.
    dwell = 16'd2; blank = 8'd2; mask = 4'hF;
    do_reset();
    run = 1;
    for (int i = 0; i < 34; i++) begin
      step();
      check("gap_sel", int'(Sel), (i / 4) % 4);
      check("gap_en", int'(En), ((i % 4) < 2) ? 1 : 0);
      check("gap_frame", int'(frame), (i % 16 == 0) ? 1 : 0);
    end

    // Sparse mask 1010 then single slot 0100.
    dwell = 16'd1; blank = 8'd0; mask = 4'b1010;
    do_reset();
    run = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("m1010_sel", int'(Sel), (i % 2 == 0) ? 1 : 3);
      check("m1010_frame", int'(frame), (i % 2 == 0) ? 1 : 0);
    end
    mask = 4'b0100;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check("single_sel", int'(Sel), 2);
      check("single_en", int'(En), 1);
      check("single_frame", int'(frame), 1);
    end

    // dwell=0 behaves like dwell=1.
    dwell = 16'd0; blank = 8'd0; mask = 4'hF;
    do_reset();
    run = 1;
    for (int i = 0; i < 9; i++) begin
      step();
      check("d0_sel", int'(Sel), i % 4);
      check("d0_frame", int'(frame), (i % 4 == 0) ? 1 : 0);
    end

    // run dropped mid-ON aborts on the next edge with Sel held.
    dwell = 16'd5; mask = 4'b1000;
    do_reset();
    run = 1;
    step(); step();
    run = 0;
    step();
    check("abort_en", int'(En), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_sel", int'(Sel), 3);

    // mask cleared mid-dwell: slot completes, then idle.
    dwell = 16'd4; mask = 4'hF;
    do_reset();
    run = 1;
    step();
    mask = 4'd0;
    for (int i = 1; i < 4; i++) begin
      step();
      check("mclr_en", int'(En), 1);
      check("mclr_busy", int'(busy), 1);
    end
    step();
    check("mclr_idle_busy", int'(busy), 0);
    check("mclr_idle_en", int'(En), 0);
    check("mclr_idle_sel", int'(Sel), 0);

    // Reset during the blanking gap.
    dwell = 16'd1; blank = 8'd5; mask = 4'b0100;
    do_reset();
    run = 1;
    step();
    check("bl_on_sel", int'(Sel), 2);
    step();
    check("bl_gap_en", int'(En), 0);
    check("bl_gap_busy", int'(busy), 1);
    rst = 1;
    step();
    check("bl_rst_sel", int'(Sel), 0);
    check("bl_rst_en", int'(En), 0);
    check("bl_rst_busy", int'(busy), 0);
    rst = 0;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom % 64 == 0);
      run = ($urandom % 16 != 0);
      if ($urandom % 8 == 0) dwell = 16'($urandom % 5);
      if ($urandom % 8 == 0) blank = 8'($urandom % 4);
      if ($urandom % 8 == 0) mask  = 4'($urandom % 16);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
